// File: rtl/logger_frame_decoder_pkg.sv
// Shared record layout, flag positions and FSM encoding for the IAGC log frame decoder.
// Each 7-byte record is little-endian: ref, err, quotient, fractional, then the flag byte.
package iagc_log_pkg;
  localparam int LOG_FRAME_BYTES = 7;

  localparam logic [2:0] LOG_B_REF_LO     = 3'd0;
  localparam logic [2:0] LOG_B_REF_HI     = 3'd1;
  localparam logic [2:0] LOG_B_ERR_LO     = 3'd2;
  localparam logic [2:0] LOG_B_ERR_HI     = 3'd3;
  localparam logic [2:0] LOG_B_QUOTIENT   = 3'd4;
  localparam logic [2:0] LOG_B_FRACTIONAL = 3'd5;
  localparam logic [2:0] LOG_B_FLAGS      = 3'd6;

  localparam int LOG_FLAG_ONPHASE = 0;
  localparam int LOG_FLAG_WDVALID = 1;

  typedef enum logic {
    LOG_ST_IDLE    = 1'b0,
    LOG_ST_COLLECT = 1'b1
  } log_state_e;

  // Upper six bits of the flag byte are reserved and must be zero.
  function automatic logic log_flags_ok(input logic [7:0] i_flags);
    return i_flags[7:2] == 6'd0;
  endfunction
endpackage

// File: rtl/logger_frame_decoder_if.sv
// Byte-in / decoded-record-out bundle between uart_rx, the frame decoder and its consumer.
// Counter fields exist only when LOGGER_FRAME_COUNTERS_EN is defined.
interface logger_frame_decoder_if #(
  parameter int AMPLITUDE_DATA_SIZE = 16,
  parameter int UART_DATA_SIZE      = 8
);
  logic                           i_rxValid;
  logic [UART_DATA_SIZE-1:0]      i_rxData;
  logic [AMPLITUDE_DATA_SIZE-1:0] o_referenceAmplitude;
  logic [AMPLITUDE_DATA_SIZE-1:0] o_errorAmplitude;
  logic [UART_DATA_SIZE-1:0]      o_quotient;
  logic [UART_DATA_SIZE-1:0]      o_fractional;
  logic                           o_onPhase;
  logic                           o_wdValid;
  logic                           o_frameValid;
  logic                           o_frameError;
`ifdef LOGGER_FRAME_COUNTERS_EN
  logic [15:0]                    o_goodCount;
  logic [15:0]                    o_errorCount;
`endif

  modport master (
    output i_rxValid, i_rxData,
    input  o_referenceAmplitude, o_errorAmplitude, o_quotient, o_fractional,
    input  o_onPhase, o_wdValid, o_frameValid, o_frameError
`ifdef LOGGER_FRAME_COUNTERS_EN
    , input o_goodCount, o_errorCount
`endif
  );

  modport slave (
    input  i_rxValid, i_rxData,
    output o_referenceAmplitude, o_errorAmplitude, o_quotient, o_fractional,
    output o_onPhase, o_wdValid, o_frameValid, o_frameError
`ifdef LOGGER_FRAME_COUNTERS_EN
    , output o_goodCount, o_errorCount
`endif
  );
endinterface

// File: rtl/log_gap_timer.sv
// Inter-byte silence timer: counts while running, clears on each byte, saturates at the last count.
// o_expired is combinational from the count so the abort lands on the same cycle as the limit.
module log_gap_timer #(
  parameter int GAP_TIMEOUT_CYCLES = 250000
) (
  input  logic i_clock,
  input  logic i_nReset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expired
);
  localparam int W = (GAP_TIMEOUT_CYCLES > 2) ? $clog2(GAP_TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(GAP_TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      r_count <= '0;
    end else if (!i_run || i_clear) begin
      r_count <= '0;
    end else if (r_count != LAST) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_expired = i_run && (r_count == LAST);
endmodule

// File: rtl/logger_frame_decoder.sv
// Reassembles 7-byte UART log records; outputs update together one cycle after the flag byte.
// Optional good/error counters under LOGGER_FRAME_COUNTERS_EN; no backpressure (bytes are never stalled).
module logger_frame_decoder
  import iagc_log_pkg::*;
#(
  parameter int AMPLITUDE_DATA_SIZE = 16,
  parameter int UART_DATA_SIZE      = 8,
  parameter int GAP_TIMEOUT_CYCLES  = 250000
) (
  input  logic                  i_clock,
  input  logic                  i_nReset,
  logger_frame_decoder_if.slave bus
);
  logic                           r_rxValidPrev;
  logic                           w_byteAccept;
  log_state_e                     r_state;
  log_state_e                     w_stateNext;
  logic [2:0]                     r_index;
  logic [UART_DATA_SIZE-1:0]      r_shadow [LOG_FRAME_BYTES-1];
  logic                           w_expired;
  logic                           w_commit;
  logic                           w_badFlags;
  logic                           w_timeout;
  logic [AMPLITUDE_DATA_SIZE-1:0] r_ref;
  logic [AMPLITUDE_DATA_SIZE-1:0] r_err;
  logic [UART_DATA_SIZE-1:0]      r_quotient;
  logic [UART_DATA_SIZE-1:0]      r_fractional;
  logic                           r_onPhase;
  logic                           r_wdValid;
  logic                           r_frameValid;
  logic                           r_frameError;

  // A level held high is one byte: only the rising edge is accepted.
  assign w_byteAccept = bus.i_rxValid && !r_rxValidPrev;

  log_gap_timer #(
    .GAP_TIMEOUT_CYCLES(GAP_TIMEOUT_CYCLES)
  ) u_gap_timer (
    .i_clock  (i_clock),
    .i_nReset (i_nReset),
    .i_run    (r_state == LOG_ST_COLLECT),
    .i_clear  (w_byteAccept),
    .o_expired(w_expired)
  );

  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      r_state <= LOG_ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      LOG_ST_IDLE: begin
        if (w_byteAccept) w_stateNext = LOG_ST_COLLECT;
      end
      LOG_ST_COLLECT: begin
        if (w_byteAccept && r_index == LOG_B_FLAGS) w_stateNext = LOG_ST_IDLE;
        else if (!w_byteAccept && w_expired)        w_stateNext = LOG_ST_IDLE;
      end
      default: w_stateNext = LOG_ST_IDLE;
    endcase
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  always_comb begin
    w_commit   = 1'b0;
    w_badFlags = 1'b0;
    w_timeout  = 1'b0;
    if (r_state == LOG_ST_COLLECT) begin
      if (w_byteAccept && r_index == LOG_B_FLAGS) begin
        w_commit   = log_flags_ok(bus.i_rxData);
        w_badFlags = !log_flags_ok(bus.i_rxData);
      end
      w_timeout = !w_byteAccept && w_expired;
    end
  end

  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      r_rxValidPrev <= 1'b0;
      r_index       <= '0;
      for (int i = 0; i < LOG_FRAME_BYTES - 1; i++) r_shadow[i] <= '0;
    end else begin
      r_rxValidPrev <= bus.i_rxValid;
      if (w_stateNext == LOG_ST_IDLE) begin
        r_index <= '0;
      end else if (w_byteAccept) begin
        for (int i = 0; i < LOG_FRAME_BYTES - 1; i++) begin
          if (r_index == 3'(i)) r_shadow[i] <= bus.i_rxData;
        end
        r_index <= r_index + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      r_ref        <= '0;
      r_err        <= '0;
      r_quotient   <= '0;
      r_fractional <= '0;
      r_onPhase    <= 1'b0;
      r_wdValid    <= 1'b0;
      r_frameValid <= 1'b0;
      r_frameError <= 1'b0;
    end else begin
      r_frameValid <= w_commit;
      r_frameError <= w_badFlags || w_timeout;
      if (w_commit) begin
        r_ref        <= {r_shadow[LOG_B_REF_HI], r_shadow[LOG_B_REF_LO]};
        r_err        <= {r_shadow[LOG_B_ERR_HI], r_shadow[LOG_B_ERR_LO]};
        r_quotient   <= r_shadow[LOG_B_QUOTIENT];
        r_fractional <= r_shadow[LOG_B_FRACTIONAL];
        r_onPhase    <= bus.i_rxData[LOG_FLAG_ONPHASE];
        r_wdValid    <= bus.i_rxData[LOG_FLAG_WDVALID];
      end
    end
  end

  assign bus.o_referenceAmplitude = r_ref;
  assign bus.o_errorAmplitude     = r_err;
  assign bus.o_quotient           = r_quotient;
  assign bus.o_fractional         = r_fractional;
  assign bus.o_onPhase            = r_onPhase;
  assign bus.o_wdValid            = r_wdValid;
  assign bus.o_frameValid         = r_frameValid;
  assign bus.o_frameError         = r_frameError;

`ifdef LOGGER_FRAME_COUNTERS_EN
  logic [15:0] r_goodCount;
  logic [15:0] r_errorCount;

  // Counts step on the same edge that raises the matching pulse.
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      r_goodCount  <= '0;
      r_errorCount <= '0;
    end else begin
      if (w_commit)                r_goodCount  <= r_goodCount + 16'd1;
      if (w_badFlags || w_timeout) r_errorCount <= r_errorCount + 16'd1;
    end
  end

  assign bus.o_goodCount  = r_goodCount;
  assign bus.o_errorCount = r_errorCount;
`endif
endmodule

// File: tb/tb_logger_frame_decoder.sv
// Bench for logger_frame_decoder: directed record scenarios plus random records against a byte-queue model.
// Define LOGGER_FRAME_COUNTERS_EN at compile time to also check the counters.
module tb_logger_frame_decoder;
  localparam int GAP = 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logger_frame_decoder_if #(.AMPLITUDE_DATA_SIZE(16), .UART_DATA_SIZE(8)) bus ();

  logger_frame_decoder #(
    .AMPLITUDE_DATA_SIZE(16),
    .UART_DATA_SIZE     (8),
    .GAP_TIMEOUT_CYCLES (GAP)
  ) dut (
    .i_clock (clk),
    .i_nReset(rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending bytes of the current record and the last committed record.
  logic [7:0]  q[$];
  logic [15:0] exp_ref = '0, exp_err = '0;
  logic [7:0]  exp_q = '0, exp_f = '0;
  logic        exp_on = 1'b0, exp_wd = 1'b0;
  int          exp_good = 0, exp_bad = 0;
  int          exp_good_cnt = 0, exp_bad_cnt = 0;

  int obs_good = 0, obs_bad = 0, obs_both = 0;

  always @(negedge clk) begin
    if (bus.o_frameValid) obs_good++;
    if (bus.o_frameError) obs_bad++;
    if (bus.o_frameValid && bus.o_frameError) obs_both++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    q.push_back(b);
    if (q.size() == 7) begin
      if (q[6][7:2] != 6'd0) begin
        exp_bad++;
        exp_bad_cnt++;
      end else begin
        exp_good++;
        exp_good_cnt++;
        exp_ref = {q[1], q[0]};
        exp_err = {q[3], q[2]};
        exp_q   = q[4];
        exp_f   = q[5];
        exp_on  = q[6][0];
        exp_wd  = q[6][1];
      end
      q.delete();
    end
  endtask

  // One byte: valid raised for 'hold' cycles, slot of at least 20 cycles (10 idle after long holds).
  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    bus.i_rxValid = 1'b1;
    bus.i_rxData  = b;
    repeat (hold) @(negedge clk);
    bus.i_rxValid = 1'b0;
    repeat ((hold >= 20) ? 10 : 20 - hold) @(negedge clk);
    model_push(b);
  endtask

  // Bytes are accepted ~20 cycles before the silence starts.
  task automatic silence(input int n);
    repeat (n) @(negedge clk);
    if (n + 20 > GAP && q.size() > 0) begin
      exp_bad++;
      exp_bad_cnt++;
      q.delete();
    end
  endtask

  task automatic send_record(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
    send_byte(b0, 2); send_byte(b1, 2); send_byte(b2, 2); send_byte(b3, 2);
    send_byte(b4, 2); send_byte(b5, 2); send_byte(b6, 2);
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".ref"},   32'(bus.o_referenceAmplitude), 32'(exp_ref));
    check_eq({tag, ".err"},   32'(bus.o_errorAmplitude),     32'(exp_err));
    check_eq({tag, ".quot"},  32'(bus.o_quotient),           32'(exp_q));
    check_eq({tag, ".frac"},  32'(bus.o_fractional),         32'(exp_f));
    check_eq({tag, ".on"},    32'(bus.o_onPhase),            32'(exp_on));
    check_eq({tag, ".wd"},    32'(bus.o_wdValid),            32'(exp_wd));
    check_eq({tag, ".nGood"}, 32'(obs_good),                 32'(exp_good));
    check_eq({tag, ".nErr"},  32'(obs_bad),                  32'(exp_bad));
    check_eq({tag, ".both"},  32'(obs_both),                 32'd0);
`ifdef LOGGER_FRAME_COUNTERS_EN
    check_eq({tag, ".goodCnt"}, 32'(bus.o_goodCount),  32'(exp_good_cnt % 65536));
    check_eq({tag, ".errCnt"},  32'(bus.o_errorCount), 32'(exp_bad_cnt % 65536));
`endif
  endtask

  initial begin
    bus.i_rxValid = 1'b0;
    bus.i_rxData  = '0;
    repeat (4) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all("post_reset");

    send_record(8'h0F, 8'h00, 8'hF0, 8'h00, 8'h50, 8'h05, 8'h02);
    check_eq("nominal.ref_const", 32'(bus.o_referenceAmplitude), 32'h000F);
    check_all("nominal");

    silence(60);
    send_record(8'h34, 8'h12, 8'h78, 8'h56, 8'h9A, 8'hBC, 8'h03);
    check_eq("b2b.ref_const", 32'(bus.o_referenceAmplitude), 32'h1234);
    check_all("b2b");

    send_byte(8'h11, 2); send_byte(8'h22, 2); send_byte(8'h33, 2);
    silence(60);
    check_all("timeout");
    send_record(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h01);
    check_all("after_timeout");

    send_record(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h06);
    check_all("bad_flags");

    send_byte(8'h55, 2); send_byte(8'h66, 2); send_byte(8'h77, 2); send_byte(8'h88, 2);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    exp_ref = '0; exp_err = '0; exp_q = '0; exp_f = '0; exp_on = 1'b0; exp_wd = 1'b0;
    exp_good_cnt = 0; exp_bad_cnt = 0;
    repeat (3) @(negedge clk);
    check_all("in_reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_record(8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, 8'h01);
    check_all("after_reset");

    send_byte(8'h9C, 30);
    send_byte(8'h5A, 2); send_byte(8'h3C, 2); send_byte(8'hC3, 2);
    send_byte(8'h0E, 2); send_byte(8'hE0, 2); send_byte(8'h02, 2);
    check_all("long_valid");

    for (int n = 0; n < 30; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        int k;
        k = $urandom_range(1, 6);
        for (int j = 0; j < k; j++) send_byte(8'($urandom), 2);
        silence($urandom_range(55, 80));
      end else begin
        logic [7:0] fl;
        for (int j = 0; j < 6; j++) send_byte(8'($urandom), $urandom_range(1, 4));
        if (r < 4) fl = {6'($urandom_range(1, 63)), 2'($urandom)};
        else       fl = {6'd0, 2'($urandom)};
        send_byte(fl, 2);
        silence($urandom_range(0, 10));
      end
      check_all("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
